// File: rtl/rsa_mont_exp_core.sv
// rtl/rsa_mont_exp_core.sv - modular exponentiation core using Montgomery products
//
// Computes o_a_pow_d = i_a^i_d mod i_n for WIDTH-bit operands.
// The base is first pre-scaled into the Montgomery domain (t = a*2^WIDTH mod n).
// The exponent is then scanned right to left. For each exponent bit, two bit-serial
// Montgomery products run side by side:
//     p1 = MP(m, t)   accumulated result; kept only when the exponent bit is 1
//     p2 = MP(t, t)   next square
// The accumulated result m starts at 1 in the plain domain. MP(m, aR) = m*a, so m
// never needs a conversion out of the Montgomery domain. The run time does not
// depend on the data.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous reset, active high
//   i_start     start request, sampled only while idle
//   i_a         base, must be below i_n
//   i_d         exponent
//   i_n         modulus, must be odd
//   o_a_pow_d   result, held until the next accepted start
//   o_finished  one-cycle completion pulse
//   o_busy      high from the cycle after the start up to and including o_finished
//   o_err       valid with o_finished; set for an even modulus or for a >= n

module rsa_mont_exp_core #(
    parameter int WIDTH = 256,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_a_pow_d,
    output logic             o_finished,
    output logic             o_busy,
    output logic             o_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREP    = 3'd1;
    localparam logic [2:0] S_EXP_MP  = 3'd2;
    localparam logic [2:0] S_EXP_UPD = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] d_sh;     // exponent; bit 0 is the current bit k
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] xs1;      // multiplier operands; bit 0 is the current step i
    logic [WIDTH-1:0] xs2;
    logic [WIDTH+1:0] acc1;
    logic [WIDTH+1:0] acc2;
    logic [WIDTH-1:0] result;
    logic             err;

    logic [WIDTH:0]   t_dbl;
    logic [WIDTH-1:0] t_prep;
    logic [WIDTH+1:0] step1;
    logic [WIDTH+1:0] step2;
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] p2;
    logic [WIDTH-1:0] m_new;

    // One step of the Montgomery product. Adding n when the sum is odd makes the
    // sum even, so the shift is exact. The accumulator stays below 2n throughout.
    function automatic logic [WIDTH+1:0] mp_step(input logic [WIDTH+1:0] acc,
                                                 input logic             xb,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] s;
        s = acc + (xb ? {2'b00, y} : '0);
        if (s[0])
            s = s + {2'b00, n};
        return s >> 1;
    endfunction

    function automatic logic [WIDTH-1:0] mont_red(input logic [WIDTH+1:0] acc,
                                                  input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] r;
        r = (acc >= {2'b00, n}) ? acc - {2'b00, n} : acc;
        return WIDTH'(r);
    endfunction

    always_comb begin
        t_dbl  = {t, 1'b0};
        t_prep = (t_dbl >= {1'b0, n_r}) ? WIDTH'(t_dbl - {1'b0, n_r}) : t_dbl[WIDTH-1:0];
        step1  = mp_step(acc1, xs1[0], t, n_r);
        step2  = mp_step(acc2, xs2[0], t, n_r);
        p1     = mont_red(acc1, n_r);
        p2     = mont_red(acc2, n_r);
        m_new  = d_sh[0] ? p1 : m;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            k      <= '0;
            n_r    <= '0;
            d_sh   <= '0;
            t      <= '0;
            m      <= '0;
            xs1    <= '0;
            xs2    <= '0;
            acc1   <= '0;
            acc2   <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        n_r    <= i_n;
                        d_sh   <= i_d;
                        t      <= i_a;
                        cnt    <= '0;
                        k      <= '0;
                        result <= '0;
                        if (!i_n[0] || (i_a >= i_n)) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    t   <= t_prep;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        k     <= '0;
                        m     <= WIDTH'(1);
                        xs1   <= WIDTH'(1);
                        xs2   <= t_prep;
                        acc1  <= '0;
                        acc2  <= '0;
                        state <= S_EXP_MP;
                    end
                end
                S_EXP_MP: begin
                    acc1 <= step1;
                    acc2 <= step2;
                    xs1  <= xs1 >> 1;
                    xs2  <= xs2 >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_EXP_UPD;
                    end
                end
                S_EXP_UPD: begin
                    m    <= m_new;
                    t    <= p2;
                    xs1  <= m_new;
                    xs2  <= p2;
                    acc1 <= '0;
                    acc2 <= '0;
                    d_sh <= d_sh >> 1;
                    k    <= k + 1'b1;
                    if (k == LAST) begin
                        // Load the result here so it is already visible during DONE.
                        result <= m_new;
                        state  <= S_DONE;
                    end else begin
                        state <= S_EXP_MP;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_a_pow_d  = result;
    assign o_finished = (state == S_DONE);
    assign o_busy     = (state != S_IDLE);
    assign o_err      = err & (state == S_DONE);

endmodule

// File: tb/tb_rsa_mont_exp_core.sv
// tb/tb_rsa_mont_exp_core.sv - self-checking bench for rsa_mont_exp_core (WIDTH 8 and 64)
`timescale 1ns/1ps

module tb_rsa_mont_exp_core;

    logic        clk;
    logic        rst;

    logic        s8;
    logic [7:0]  a8, d8, n8;
    logic [7:0]  r8;
    logic        f8, b8, e8;

    logic        s64;
    logic [63:0] a64, d64, n64;
    logic [63:0] r64;
    logic        f64, b64, e64;

    int checks;
    int errors;

    rsa_mont_exp_core #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(s8), .i_a(a8), .i_d(d8), .i_n(n8),
        .o_a_pow_d(r8), .o_finished(f8), .o_busy(b8), .o_err(e8)
    );

    rsa_mont_exp_core #(.WIDTH(64)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_start(s64), .i_a(a64), .i_d(d64), .i_n(n64),
        .o_a_pow_d(r64), .o_finished(f64), .o_busy(b64), .o_err(e64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_pow(input logic [63:0] a, input logic [63:0] d,
                                            input logic [63:0] n);
        logic [127:0] r, b, nn;
        nn = {64'd0, n};
        r  = 128'd1 % nn;
        b  = {64'd0, a} % nn;
        for (int i = 0; i < 64; i++) begin
            if (d[i])
                r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[63:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 run. inj: cycle at which a stray start with other operands is
    // driven; rstc: cycle at which reset is asserted; b2b: leave the cycle after
    // completion free so the caller can start again immediately.
    task automatic run8(input logic [7:0] a, input logic [7:0] d, input logic [7:0] n,
                        input int inj, input int rstc, input bit b2b);
        logic [63:0] exp_r;
        logic        exp_e;
        int          lat, cyc, busy_lo, fin_cnt;
        bit          done;
        exp_e = !n[0] || (a >= n);
        exp_r = exp_e ? 64'd0 : ref_pow({56'd0, a}, {56'd0, d}, {56'd0, n});
        lat   = exp_e ? 1 : 81;
        @(negedge clk);
        a8 = a; d8 = d; n8 = n; s8 = 1'b1;
        @(posedge clk);
        #1;
        s8 = 1'b0;
        a8 = 8'($urandom); d8 = 8'($urandom); n8 = 8'($urandom);
        cyc = 0; busy_lo = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == rstc) begin
                rst = 1'b1;
                #1;
                check("rst_result", {56'd0, r8}, 64'd0);
                check("rst_finished", {63'd0, f8}, 64'd0);
                check("rst_busy", {63'd0, b8}, 64'd0);
                check("rst_err", {63'd0, e8}, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                fin_cnt = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (f8) fin_cnt++;
                end
                check("rst_no_finish", 64'(fin_cnt), 64'd0);
                return;
            end
            if (cyc == inj) begin
                s8 = 1'b1; a8 = 8'h05; d8 = 8'h03; n8 = 8'hF1;
            end
            if (cyc == inj + 1)
                s8 = 1'b0;
            if (f8)
                done = 1;
            else if (!b8)
                busy_lo++;
        end
        check("finished_seen", {63'd0, done}, 64'd1);
        check("latency8", 64'(cyc), 64'(lat));
        check("result8", {56'd0, r8}, exp_r);
        check("err8", {63'd0, e8}, {63'd0, exp_e});
        check("busy_at_finish8", {63'd0, b8}, 64'd1);
        check("busy_gap8", 64'(busy_lo), 64'd0);
        if (!b2b) begin
            @(negedge clk);
            check("finish_one_cycle8", {63'd0, f8}, 64'd0);
            check("busy_idle8", {63'd0, b8}, 64'd0);
            check("result_held8", {56'd0, r8}, exp_r);
        end
    endtask

    task automatic run64(input logic [63:0] a, input logic [63:0] d, input logic [63:0] n);
        logic [63:0] exp_r;
        int          cyc;
        bit          done;
        exp_r = ref_pow(a, d, n);
        @(negedge clk);
        a64 = a; d64 = d; n64 = n; s64 = 1'b1;
        @(posedge clk);
        #1;
        s64 = 1'b0;
        a64 = {$urandom, $urandom};
        cyc = 0; done = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (f64) done = 1;
        end
        check("finished_seen64", {63'd0, done}, 64'd1);
        check("latency64", 64'(cyc), 64'd4225);
        check("result64", r64, exp_r);
        check("err64", {63'd0, e64}, 64'd0);
    endtask

    initial begin
        logic [7:0]  na, aa, da;
        logic [63:0] n_w, d_w, a_w;
        checks = 0; errors = 0;
        rst = 1'b1;
        s8 = 1'b0; a8 = '0; d8 = '0; n8 = '0;
        s64 = 1'b0; a64 = '0; d64 = '0; n64 = '0;
        repeat (3) @(negedge clk);
        check("reset_result8", {56'd0, r8}, 64'd0);
        check("reset_finished8", {63'd0, f8}, 64'd0);
        check("reset_busy8", {63'd0, b8}, 64'd0);
        check("reset_err8", {63'd0, e8}, 64'd0);
        check("reset_result64", r64, 64'd0);
        check("reset_busy64", {63'd0, b64}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed WIDTH=8 cases
        run8(8'h02, 8'h07, 8'h8F, 0, 0, 0);
        run8(8'h03, 8'h05, 8'h8F, 0, 0, 1);
        run8(8'h05, 8'h00, 8'h8F, 0, 0, 0);
        run8(8'h03, 8'h05, 8'h8E, 0, 0, 0);
        run8(8'h90, 8'h05, 8'h8F, 0, 0, 0);
        run8(8'h8F, 8'h05, 8'h8F, 0, 0, 0);
        run8(8'h2A, 8'hB3, 8'hC5, 20, 0, 0);
        run8(8'h11, 8'h77, 8'hE9, 0, 40, 0);
        run8(8'h11, 8'h77, 8'hE9, 0, 0, 0);
        run8(8'h00, 8'h9C, 8'hAB, 0, 0, 0);
        run8(8'h01, 8'hFF, 8'hAB, 0, 0, 0);
        run8(8'h00, 8'h05, 8'h01, 0, 0, 0);
        run8(8'hFC, 8'hFF, 8'hFD, 0, 0, 0);

        // random WIDTH=8 cases
        for (int i = 0; i < 8; i++) begin
            na = 8'($urandom) | 8'h81;
            aa = 8'($urandom_range(0, 32'(na) - 1));
            da = 8'($urandom);
            run8(aa, da, na, 0, 0, 0);
        end

        // random WIDTH=64 cases
        n_w = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
        d_w = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            a_w = {$urandom, $urandom} % n_w;
            run64(a_w, d_w, n_w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
